// File: rtl/fg_prog_pkg.sv
// Shared types and constants for the floating-gate programming sequencer.
package fg_prog_pkg;

  // Settle time used after any mode or address change, in clk cycles.
  localparam int SETTLE_CYC_DEF = 8;

  // Command opcodes as they arrive on cmd_op.
  typedef enum logic [1:0] {
    OP_INJ  = 2'b00,  // hot-electron injection: drain pulses
    OP_TUN  = 2'b01,  // Fowler-Nordheim tunnelling: tunnel pulses
    OP_SEL  = 2'b10,  // select the element only, no pulse
    OP_EXIT = 2'b11   // leave programming mode, back to run
  } op_e;

  // Sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ENTER,
    ST_ADDR,
    ST_PULSE,
    ST_GAP,
    ST_HOLD,
    ST_DESEL,
    ST_EXIT,
    ST_FINISH
  } state_e;

  // True for the states in which a live abort is honoured.
  function automatic logic abortable(input state_e st);
    return (st == ST_ADDR) || (st == ST_PULSE) || (st == ST_GAP) || (st == ST_HOLD);
  endfunction

  // True for the states in which the element address is presented.
  function automatic logic addr_driven(input state_e st);
    return (st == ST_ADDR) || (st == ST_PULSE) || (st == ST_GAP) ||
           (st == ST_HOLD) || (st == ST_DESEL);
  endfunction

endpackage

// File: rtl/fg_delay_timer.sv
// Loadable down-counter with a terminal flag. One instance times both the
// settle intervals and the pulse widths; the sequencer only ever needs one
// interval running at a time.
module fg_delay_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Count register: load wins, otherwise count down and park at zero.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; a blocking = here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A load of N gives N+1 cycles in the owning state before zero is seen.
  assign zero = (cnt == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming mux transmitter. Expands one accepted command
// into a timed break-before-make sequence: enter prog mode, present the
// address with the decoders disabled, enable them, pulse drain or tunnel,
// deselect, clear the address, and report done.
module fg_prog_sequencer
  import fg_prog_pkg::*;
#(
  parameter int ROW_BITS   = 6,
  parameter int COL_BITS   = 6,
  parameter int PULSE_W    = 16,
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic [PULSE_W-1:0]  cmd_pulse,
  input  logic [CNT_W-1:0]    cmd_count,
  input  logic                abort,
  output logic [ROW_BITS-1:0] row_addr,
  output logic [COL_BITS-1:0] col_addr,
  output logic                dec_en,
  output logic                prog,
  output logic                run,
  output logic                drain_pulse,
  output logic                tun_en,
  output logic                busy,
  output logic                done
);

  // Timer load values. Loading SETTLE_LEN gives a leading break cycle plus
  // SETTLE_CYC settle cycles; loading SETTLE_M1 gives exactly SETTLE_CYC.
  localparam logic [PULSE_W-1:0] SETTLE_LEN = PULSE_W'(SETTLE_CYC);
  localparam logic [PULSE_W-1:0] SETTLE_M1  = PULSE_W'(SETTLE_CYC - 1);

  state_e               state, state_next;
  logic                 prog_mode, prog_mode_next;

  // Command fields captured at acceptance.
  op_e                  op_q;
  logic [ROW_BITS-1:0]  row_q;
  logic [COL_BITS-1:0]  col_q;
  logic [PULSE_W-1:0]   pulse_q;
  logic [CNT_W-1:0]     count_q;

  logic                 accept;
  logic                 count_dec;
  logic                 tmr_load;
  logic [PULSE_W-1:0]   tmr_val;
  logic [PULSE_W-1:0]   tmr_cnt;
  logic                 tmr_zero;
  logic [PULSE_W-1:0]   pulse_len_m1;
  logic                 first_cyc;

  assign accept = cmd_valid && cmd_ready;

  // A zero pulse length still yields a single high cycle.
  assign pulse_len_m1 = (pulse_q == '0) ? '0 : pulse_q - 1'b1;

  // ENTER, ADDR and EXIT load SETTLE_LEN on entry, so the timer still holds
  // that value only during their first (break) cycle.
  assign first_cyc = (tmr_cnt == SETTLE_LEN);

  fg_delay_timer #(
    .W (PULSE_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  // State and mode flag registers; reset drops any pulse with no DESEL phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      prog_mode <= 1'b0;
    end else begin
      state     <= state_next;
      prog_mode <= prog_mode_next;
    end
  end

  // Command capture and remaining-pulse count.
  // NOTE: these datapath registers are deliberately not reset; they are only
  // observed outside IDLE, which is reachable solely through an accept that
  // loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op_e'(cmd_op);
      row_q   <= cmd_row;
      col_q   <= cmd_col;
      pulse_q <= cmd_pulse;
      count_q <= cmd_count;
    end else if (count_dec) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Next-state logic and timer loads for every transition.
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    prog_mode_next = prog_mode;
    tmr_load       = 1'b0;
    tmr_val        = '0;
    count_dec      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LEN;
          if (op_e'(cmd_op) == OP_EXIT) begin
            state_next = prog_mode ? ST_EXIT : ST_FINISH;
          end else begin
            state_next = prog_mode ? ST_ADDR : ST_ENTER;
          end
        end
      end

      ST_ENTER: begin
        if (tmr_zero) begin
          state_next     = ST_ADDR;
          prog_mode_next = 1'b1;
          tmr_load       = 1'b1;
          tmr_val        = SETTLE_LEN;
        end
      end

      ST_ADDR: begin
        if (abort) begin
          state_next = ST_DESEL;
          tmr_load   = 1'b1;
          tmr_val    = SETTLE_M1;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          if (op_q == OP_SEL) begin
            state_next = ST_HOLD;
            tmr_val    = SETTLE_M1;
          end else if (count_q == '0) begin
            state_next = ST_HOLD;
            tmr_val    = '0;
          end else begin
            state_next = ST_PULSE;
            tmr_val    = pulse_len_m1;
          end
        end
      end

      ST_PULSE: begin
        if (abort) begin
          state_next = ST_DESEL;
          tmr_load   = 1'b1;
          tmr_val    = SETTLE_M1;
        end else if (tmr_zero) begin
          count_dec = 1'b1;
          tmr_load  = 1'b1;
          // count_q is at least 1 here, so "1" means this was the last pulse.
          if (count_q != CNT_W'(1)) begin
            state_next = ST_GAP;
            tmr_val    = SETTLE_M1;
          end else begin
            state_next = ST_HOLD;
            tmr_val    = '0;
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_next = ST_DESEL;
          tmr_load   = 1'b1;
          tmr_val    = SETTLE_M1;
        end else if (tmr_zero) begin
          state_next = ST_PULSE;
          tmr_load   = 1'b1;
          tmr_val    = pulse_len_m1;
        end
      end

      ST_HOLD: begin
        if (abort || tmr_zero) begin
          state_next = ST_DESEL;
          tmr_load   = 1'b1;
          tmr_val    = SETTLE_M1;
        end
      end

      ST_DESEL: begin
        if (tmr_zero) begin
          state_next = ST_FINISH;
        end
      end

      ST_EXIT: begin
        if (tmr_zero) begin
          state_next     = ST_FINISH;
          prog_mode_next = 1'b0;
        end
      end

      ST_FINISH: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state: mode lines, decoder bus, pulses.
  always_comb begin
    run         = 1'b0;
    prog        = 1'b0;
    dec_en      = 1'b0;
    row_addr    = '0;
    col_addr    = '0;
    drain_pulse = 1'b0;
    tun_en      = 1'b0;
    busy        = (state != ST_IDLE);
    done        = (state == ST_FINISH);
    cmd_ready   = (state == ST_IDLE) && !reset;

    // Mode lines: ENTER and EXIT open a one-cycle gap with both low.
    unique case (state)
      ST_ENTER: prog = !first_cyc;
      ST_EXIT:  run  = !first_cyc;
      default: begin
        prog = prog_mode;
        run  = !prog_mode;
      end
    endcase

    // Address is presented one cycle before the decoders are enabled and is
    // held through DESEL, so it only ever changes while dec_en is low.
    if (addr_driven(state)) begin
      row_addr = row_q;
      col_addr = col_q;
    end

    unique case (state)
      ST_ADDR:  dec_en = !first_cyc;
      ST_PULSE: begin
        dec_en      = 1'b1;
        drain_pulse = (op_q == OP_INJ);
        tun_en      = (op_q == OP_TUN);
      end
      ST_GAP:   dec_en = 1'b1;
      ST_HOLD:  dec_en = 1'b1;
      default:  dec_en = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer. A monitor measures pulse activity per
// command and checks it against expectations queued when each command is sent;
// it also watches the break-before-make invariants every cycle.
module tb_fg_prog_sequencer;
  import fg_prog_pkg::*;

  localparam int RB = 6;
  localparam int CB = 6;
  localparam int PW = 16;
  localparam int CW = 8;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [RB-1:0] cmd_row;
  logic [CB-1:0] cmd_col;
  logic [PW-1:0] cmd_pulse;
  logic [CW-1:0] cmd_count;
  logic          abort;
  logic [RB-1:0] row_addr;
  logic [CB-1:0] col_addr;
  logic          dec_en;
  logic          prog;
  logic          run;
  logic          drain_pulse;
  logic          tun_en;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int drain_n;
    int tun_n;
    int high;
    int gap;
  } exp_t;

  exp_t sb_q[$];

  fg_prog_sequencer #(
    .ROW_BITS   (RB),
    .COL_BITS   (CB),
    .PULSE_W    (PW),
    .CNT_W      (CW),
    .SETTLE_CYC (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_row     (cmd_row),
    .cmd_col     (cmd_col),
    .cmd_pulse   (cmd_pulse),
    .cmd_count   (cmd_count),
    .abort       (abort),
    .row_addr    (row_addr),
    .col_addr    (col_addr),
    .dec_en      (dec_en),
    .prog        (prog),
    .run         (run),
    .drain_pulse (drain_pulse),
    .tun_en      (tun_en),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until accepted; returns just after the
  // accepting edge.
  task automatic send(input op_e op, input int row, input int col,
                      input int pulse, input int count);
    int n;
    cmd_op    = op;
    cmd_row   = RB'(row);
    cmd_col   = CB'(col);
    cmd_pulse = PW'(pulse);
    cmd_count = CW'(count);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      tick();
      n++;
    end
    check("send_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic wait_drain(input logic lvl, input int bound);
    int n;
    n = 0;
    while (drain_pulse !== lvl && n < bound) begin
      tick();
      n++;
    end
    check("drain_wait", drain_pulse, lvl);
  endtask

  // Monitor state.
  int             m_drain, m_tun, m_high, m_gap, m_low;
  logic           prev_pulse, prev_dec, prev_reset = 1'b1;
  logic [RB+CB-1:0] prev_addr;
  exp_t           m_exp;

  // Per-cycle invariants and per-command pulse measurement, sampled on the
  // falling edge away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      m_drain    = 0;
      m_tun      = 0;
      m_high     = 0;
      m_gap      = 0;
      m_low      = 0;
      prev_reset = 1'b1;
    end else begin
      check("inv_run_prog", run && prog, 0);
      check("inv_drain_tun", drain_pulse && tun_en, 0);
      check("inv_pulse_dec", (drain_pulse || tun_en) && !dec_en, 0);
      if ({row_addr, col_addr} != prev_addr && !prev_reset)
        check("inv_addr_dec", {30'd0, prev_dec, dec_en}, 0);

      if (drain_pulse || tun_en) begin
        if (!prev_pulse) begin
          if (m_drain + m_tun > 0) m_gap = m_low;
          if (drain_pulse) m_drain++;
          else m_tun++;
        end
        m_high++;
      end else if (prev_pulse) begin
        m_low = 1;
      end else begin
        m_low++;
      end

      if (done) begin
        check("sb_pending", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          m_exp = sb_q.pop_front();
          check("sb_drain_pulses", m_drain, m_exp.drain_n);
          check("sb_tun_pulses", m_tun, m_exp.tun_n);
          check("sb_high_cycles", m_high, m_exp.high);
          check("sb_gap", m_gap, m_exp.gap);
        end
        m_drain = 0;
        m_tun   = 0;
        m_high  = 0;
        m_gap   = 0;
      end
      prev_reset = 1'b0;
    end
    prev_pulse = drain_pulse || tun_en;
    prev_dec   = dec_en;
    prev_addr  = {row_addr, col_addr};
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_row   = '0;
    cmd_col   = '0;
    cmd_pulse = '0;
    cmd_count = '0;
    abort     = 1'b0;
    repeat (3) tick();

    // Reset values.
    check("rst_run", run, 1);
    check("rst_prog", prog, 0);
    check("rst_dec_en", dec_en, 0);
    check("rst_addr", {row_addr, col_addr}, 0);
    check("rst_pulses", {drain_pulse, tun_en}, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_ready", cmd_ready, 0);
    reset = 1'b0;
    #1;
    check("idle_ready", cmd_ready, 1);
    tick();

    // Inject row 5 col 9, two 4-cycle pulses.
    sb_q.push_back('{drain_n: 2, tun_n: 0, high: 8, gap: 8});
    send(OP_INJ, 5, 9, 4, 2);
    check("enter_run_low", run, 0);
    check("enter_prog_low", prog, 0);
    check("enter_busy", busy, 1);
    tick();
    check("enter_prog_high", prog, 1);
    begin
      int n = 0;
      while (row_addr == '0 && n < 100) begin
        tick();
        n++;
      end
    end
    check("addr_row", row_addr, 5);
    check("addr_col", col_addr, 9);
    check("addr_dec_low", dec_en, 0);
    tick();
    check("addr_dec_high", dec_en, 1);
    wait_done(500);
    tick();
    check("done_one_cycle", done, 0);
    check("stay_prog", prog, 1);
    check("stay_run_low", run, 0);
    check("idle_not_busy", busy, 0);

    // Tunnel with count 0 while already in prog mode: straight to ADDR.
    sb_q.push_back('{drain_n: 0, tun_n: 0, high: 0, gap: 0});
    send(OP_TUN, 3, 2, 10, 0);
    check("tun0_row", row_addr, 3);
    check("tun0_col", col_addr, 2);
    check("tun0_dec_low", dec_en, 0);
    check("tun0_prog", prog, 1);
    wait_done(200);
    tick();

    // Zero pulse length gives one high cycle.
    sb_q.push_back('{drain_n: 1, tun_n: 0, high: 1, gap: 0});
    send(OP_INJ, 1, 1, 0, 1);
    wait_done(200);
    tick();

    // Abort on the 3rd cycle of a 100-cycle pulse.
    sb_q.push_back('{drain_n: 1, tun_n: 0, high: 3, gap: 0});
    send(OP_INJ, 7, 7, 100, 1);
    wait_drain(1'b1, 100);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_drain_low", drain_pulse, 0);
    check("abort_desel_dec", dec_en, 0);
    check("abort_desel_row", row_addr, 7);
    wait_done(100);
    tick();

    // Count 255: exactly 255 single-cycle pulses.
    sb_q.push_back('{drain_n: 255, tun_n: 0, high: 255, gap: 8});
    send(OP_INJ, 2, 4, 0, 255);
    wait_done(4000);
    tick();

    // Long tunnel pulse.
    sb_q.push_back('{drain_n: 0, tun_n: 1, high: 300, gap: 0});
    send(OP_TUN, 9, 3, 300, 1);
    wait_done(600);
    tick();

    // Reset during GAP.
    send(OP_INJ, 6, 6, 2, 3);
    wait_drain(1'b1, 100);
    wait_drain(1'b0, 100);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("gaprst_run", run, 1);
    check("gaprst_prog", prog, 0);
    check("gaprst_dec", dec_en, 0);
    check("gaprst_addr", {row_addr, col_addr}, 0);
    check("gaprst_busy", busy, 0);
    check("gaprst_drain", drain_pulse, 0);
    reset = 1'b0;
    tick();

    // Select-only re-enters prog mode, then exit.
    sb_q.push_back('{drain_n: 0, tun_n: 0, high: 0, gap: 0});
    send(OP_SEL, 4, 4, 5, 3);
    wait_done(200);
    tick();
    check("sel_prog", prog, 1);
    sb_q.push_back('{drain_n: 0, tun_n: 0, high: 0, gap: 0});
    send(OP_EXIT, 0, 0, 0, 0);
    check("exit_prog_low", prog, 0);
    check("exit_run_low", run, 0);
    tick();
    check("exit_run_high", run, 1);
    check("exit_prog_stays", prog, 0);
    wait_done(100);
    tick();
    check("exit_idle_run", run, 1);

    // Second exit, with a simultaneous abort in IDLE: done only.
    sb_q.push_back('{drain_n: 0, tun_n: 0, high: 0, gap: 0});
    abort = 1'b1;
    send(OP_EXIT, 0, 0, 0, 0);
    abort = 1'b0;
    check("exit2_done", done, 1);
    check("exit2_run", run, 1);
    check("exit2_prog", prog, 0);
    check("exit2_busy", busy, 1);
    tick();
    check("exit2_done_drop", done, 0);
    check("exit2_idle", busy, 0);
    tick();

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fg_prog_sequencer.md
Name: fg_prog_sequencer

Overview:
Digital transmitter for the floating-gate programming mux. It drives the address bits of the horizontal and vertical VinjDecode2to4 decoder chains, the prog/run mode lines and the drain-select/tunnel pulse enables that the array tiles receive. Commands arrive over a valid/ready interface. Each command is expanded into a timed, break-before-make programming sequence for one array element. One instance exists per island.

Parameters:
ROW_BITS, 6, vertical decoder address width
COL_BITS, 6, horizontal decoder address width
PULSE_W, 16, width of the pulse-length field, in clk cycles
CNT_W, 8, width of the repeat-count field
SETTLE_CYC, 8, settle time in cycles after any mode or address change (minimum 1)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  00 inject, 01 tunnel, 10 select-only, 11 exit to run
cmd_row  in  ROW_BITS  target row
cmd_col  in  COL_BITS  target column
cmd_pulse  in  PULSE_W  pulse length in cycles
cmd_count  in  CNT_W  number of pulses
abort  in  1  terminate the current command
row_addr  out  ROW_BITS  vertical decoder bits
col_addr  out  COL_BITS  horizontal decoder bits
dec_en  out  1  decoder enable (both axes)
prog  out  1  programming mode
run  out  1  run mode; never high together with prog
drain_pulse  out  1  injection drain pulse
tun_en  out  1  tunnelling pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a command completes or aborts

Behaviour:
- Reset values: run=1; all other outputs 0. After reset the FSM is in IDLE and the prog_mode flag is cleared.
- cmd_ready=1 only in IDLE. Commands are accepted at most one per cycle. All cmd fields are latched at acceptance.
- States and transitions:
  - IDLE: on accept, if op=11 and prog_mode=0, go to FINISH (done only). Otherwise, if prog_mode=0, go to ENTER. If prog_mode=1, op=11 goes to EXIT and every other op goes to ADDR.
  - ENTER: run=0 on the first cycle and prog=1 on the next cycle, so run and prog are never both high. Wait SETTLE_CYC cycles, set prog_mode, go to ADDR.
  - ADDR: drive row_addr/col_addr with dec_en=0 for 1 cycle, then dec_en=1. Wait SETTLE_CYC cycles, then go to PULSE. For select-only, or count=0, go straight to HOLD.
  - PULSE: drain_pulse (op 00) or tun_en (op 01) is high for max(cmd_pulse,1) consecutive cycles. Then decrement the remaining count. If it is nonzero go to GAP, else go to HOLD.
  - GAP: pulse outputs low for SETTLE_CYC cycles, then return to PULSE.
  - HOLD: for select-only, dec_en stays high for SETTLE_CYC cycles. For all ops, then go to DESEL.
  - DESEL: dec_en=0 while the address is held. Wait SETTLE_CYC cycles. Then row_addr/col_addr go to 0, and the FSM goes to FINISH.
  - EXIT: prog=0 on the first cycle and run=1 on the next. Wait SETTLE_CYC cycles, clear prog_mode, go to FINISH.
  - FINISH: done=1 for one cycle, then go to IDLE.
- Break-before-make:
  - Address bits change only while dec_en=0.
  - A pulse output is never high while dec_en=0.
  - drain_pulse and tun_en are never high together.
- abort, sampled in ADDR/PULSE/GAP/HOLD:
  - Pulse outputs drop on the next edge and the FSM goes to DESEL.
  - abort is ignored in IDLE (a simultaneous cmd_valid is still accepted) and in ENTER, DESEL, EXIT and FINISH.
- reset in any state, including mid-pulse: at the next edge all outputs take their reset values. The pulse ends with no DESEL phase and prog_mode clears.
- Counters:
  - Pulse and settle counters are down-counters, so no wrap-around is possible.
  - cmd_count=255 produces exactly 255 pulses.
  - cmd_pulse=65535 produces exactly 65535 high cycles.

Decomposition:
- Package fg_prog_pkg holds:
  - the op encoding enum (OP_INJ, OP_TUN, OP_SEL, OP_EXIT);
  - the FSM state enum;
  - the default SETTLE_CYC.
- Sub-module fg_delay_timer: loadable down-counter with a terminal flag. It is shared by the settle and pulse timing.

Test Plan:
- Reset, then inject row=5 col=9 pulse=4 count=2 with SETTLE_CYC=8:
  - run falls, prog rises 1 cycle later;
  - addresses appear with dec_en=0, and dec_en rises 1 cycle later;
  - two 4-cycle drain_pulse pulses separated by an 8-cycle gap;
  - dec_en falls before the address clears;
  - one-cycle done; prog stays 1.
- Tunnel with count=0 while in prog mode:
  - no tun_en activity;
  - addresses select, then deselect;
  - done; ENTER is not re-entered.
- cmd_pulse=0, count=1: drain_pulse is high for exactly 1 cycle.
- abort on the 3rd cycle of a 100-cycle pulse:
  - drain_pulse is low at the next edge;
  - DESEL sequence follows; done fires.
- reset during GAP: the cycle after the edge, run=1, prog=0, dec_en=0, addresses=0 and busy=0.
- Exit command: prog falls, run rises the next cycle (never both high), then done. A further exit command gives done only, with no change on any mode line.
